// File: rtl/fifo_stream_out.sv
// fifo_stream_out: drains a fifo_sync read port into a valid/ready stream.
// The FIFO's dout arrives one cycle after a read strobe. A two-entry buffer
// (head/tail) plus an in-flight flag lets a new read be issued every cycle
// while m_ready is held high. The same buffer soaks up reads that are already
// committed when the sink stalls.
module fifo_stream_out #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            level
);

    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  pop;
    logic [1:0]            occ_after_pop;
    logic [2:0]            committed;

    assign m_valid = (occ != 2'd0);
    assign m_data  = head;
    assign level   = occ;

    // Read issue: only read when the word (plus anything already buffered or
    // in flight, minus this cycle's pop) is guaranteed a slot next cycle.
    always_comb begin
        pop           = 1'b0;
        occ_after_pop = occ;
        committed     = 3'd0;
        fifo_rd_en    = 1'b0;
        pop           = m_valid && m_ready;
        occ_after_pop = occ - {1'b0, pop};
        committed     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        fifo_rd_en    = reset_n && !flush && !fifo_empty && (committed < 3'd2);
    end

    // Buffer update: pop shifts tail into head, then the arriving word lands
    // in the first slot that is free after the pop, keeping strict order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head     <= '0;
            tail     <= '0;
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else if (flush) begin
            // The word landing on this edge and anything buffered are dropped;
            // no read is issued during flush, so nothing arrives afterwards.
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            occ      <= occ_after_pop + {1'b0, inflight};
            if (pop) begin
                head <= tail;
            end
            if (inflight) begin
                if (occ_after_pop == 2'd0) begin
                    head <= fifo_dout;
                end else begin
                    tail <= fifo_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench for fifo_stream_out with a behavioural fifo_sync read port.
module tb_fifo_stream_out;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic       flush = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [1:0] level;

    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr;

    int n_chk = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int bad_rd = 0;
    int bad_inv = 0;
    int bad_stab = 0;
    int r0;
    logic       inflight_m;
    logic       hold_prev;
    logic [7:0] hold_data;
    logic [7:0] rx_q [$];

    fifo_stream_out #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Behavioural FIFO read port: registered dout, one cycle after rd_en.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= 8'd0;
            fifo_dout <= 8'd0;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    // Stream monitor: collects popped beats and tracks protocol violations.
    always @(posedge clk) begin
        if (!reset_n) begin
            inflight_m <= 1'b0;
            hold_prev  <= 1'b0;
        end else begin
            if (m_valid && m_ready) rx_q.push_back(m_data);
            if (fifo_rd_en) rd_cnt++;
            if (fifo_rd_en && fifo_empty) bad_rd++;
            if (int'(level) + int'(inflight_m) > 2) bad_inv++;
            if (hold_prev && (!m_valid || m_data != hold_data)) bad_stab++;
            inflight_m <= fifo_rd_en;
            hold_prev  <= m_valid && !m_ready && !flush;
            hold_data  <= m_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = first + 8'(i);
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single word, sink always ready
        rx_q.delete();
        r0 = rd_cnt;
        m_ready = 1'b1;
        preload(8'hA5, 1);
        #1 chk("t1_rd_issue", 32'(fifo_rd_en), 32'd1);
        @(negedge clk); #1;
        chk("t1_rd_once", 32'(fifo_rd_en), 32'd0);
        chk("t1_valid_wait", 32'(m_valid), 32'd0);
        @(negedge clk); #1;
        chk("t1_valid", 32'(m_valid), 32'd1);
        chk("t1_data", 32'(m_data), 32'hA5);
        chk("t1_level", 32'(level), 32'd1);
        @(negedge clk); #1;
        chk("t1_valid_drop", 32'(m_valid), 32'd0);
        chk("t1_level0", 32'(level), 32'd0);
        chk("t1_rd_count", 32'(rd_cnt - r0), 32'd1);

        // 8 preloaded words at full rate
        @(negedge clk);
        rx_q.delete();
        preload(8'h00, 8);
        @(negedge clk);
        @(negedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_valid", 32'(m_valid), 32'd1);
            chk("t2_data", 32'(m_data), 32'(i));
            @(negedge clk); #1;
        end
        chk("t2_valid_end", 32'(m_valid), 32'd0);

        // back-pressure: two reads absorbed, then drained back-to-back
        @(negedge clk);
        rx_q.delete();
        m_ready = 1'b0;
        r0 = rd_cnt;
        preload(8'h00, 4);
        repeat (4) @(negedge clk);
        #1;
        chk("t3_level", 32'(level), 32'd2);
        chk("t3_data_held", 32'(m_data), 32'h00);
        chk("t3_rd_idle", 32'(fifo_rd_en), 32'd0);
        chk("t3_rd_count", 32'(rd_cnt - r0), 32'd2);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_valid", 32'(m_valid), 32'd1);
            chk("t3_data", 32'(m_data), 32'(i));
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);
        chk("t3_rx_count", 32'(rx_q.size()), 32'd4);

        // toggling ready over 16 words
        rx_q.delete();
        m_ready = 1'b0;
        preload(8'h10, 16);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            m_ready = ~m_ready;
        end
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_rx_count", 32'(rx_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t4_rx_word", 32'(rx_q[i]), 32'(8'h10 + 8'(i)));
        end

        // flush with one word buffered and one in flight
        @(negedge clk);
        rx_q.delete();
        m_ready = 1'b0;
        preload(8'h40, 4);
        @(negedge clk);
        @(negedge clk); #1;
        chk("t5_level_pre", 32'(level), 32'd1);
        chk("t5_data_pre", 32'(m_data), 32'h40);
        flush = 1'b1;
        #1 chk("t5_rd_blocked", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("t5_valid_post", 32'(m_valid), 32'd0);
        chk("t5_level_post", 32'(level), 32'd0);
        m_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_rx_count", 32'(rx_q.size()), 32'd2);
        chk("t5_rx_first", 32'(rx_q[0]), 32'h42);
        chk("t5_rx_second", 32'(rx_q[1]), 32'h43);

        // asynchronous reset mid-stream
        @(negedge clk);
        preload(8'h60, 16);
        repeat (5) @(negedge clk);
        #3;
        chk("t6_valid_pre", 32'(m_valid), 32'd1);
        reset_n = 1'b0;
        wr_ptr = 8'd0;
        #1;
        chk("t6_valid", 32'(m_valid), 32'd0);
        chk("t6_data", 32'(m_data), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("t6_valid_after", 32'(m_valid), 32'd0);

        chk("rd_while_empty", 32'(bad_rd), 32'd0);
        chk("occ_inflight_le2", 32'(bad_inv), 32'd0);
        chk("stall_stability", 32'(bad_stab), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
